// File: rtl/data_mem_ctrl_pkg.sv
// Shared types and constants for the data-memory controller and its neighbours
// in the execute/memory stage.
package data_mem_ctrl_pkg;

  localparam int ADDR_W_DEF  = 64;
  localparam int DATA_W_DEF  = 64;
  localparam int TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_SD   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // A doubleword access needs exactly one direction and 8-byte alignment.
  function automatic logic access_legal(input logic rd, input logic wr,
                                        input logic [2:0] lsb);
    return (rd ^ wr) && (lsb == 3'b000);
  endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Request/grant/response bus between the controller and the data memory.
interface data_mem_ctrl_if
  import data_mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/data_mem_ctrl_timeout.sv
// Saturating cycle counter; expired flags the last cycle an access may spend
// outstanding before it is aborted.
module data_mem_ctrl_timeout
  import data_mem_ctrl_pkg::*;
#(
  parameter int LIMIT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && (count != CW'(LIMIT))) begin
      count <= count + 1'b1;
    end
  end

  // count holds the cycles already spent, so this cycle is number count+1.
  assign expired = enable && (count >= CW'(LIMIT - 1));
endmodule

// File: rtl/data_mem_ctrl.sv
// Multi-cycle ld/sd controller: stalls the pipeline while one doubleword access
// runs over the request/grant/response bus, and flags illegal or timed-out accesses.
//   state  | meaning
//   IDLE   | no access outstanding; a legal request is latched here
//   REQ    | mem_req high, waiting for mem_gnt
//   WAIT_R | read granted, waiting for mem_rvalid
//   DONE   | access retires, pipeline advances
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              stall,
  output logic              done,
  output logic              err,
  data_mem_ctrl_if.master   mem
);
  state_t state, state_nx;
  logic   legal, expired, busy;
  logic   err_nx, latch_req, cap_rdata, clr_rdata;

  assign legal = access_legal(MemRead, MemWrite, addr[2:0]);
  assign busy  = (state == REQ) || (state == WAIT_R);

  data_mem_ctrl_timeout #(.LIMIT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (latch_req),
    .enable  (busy),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      err           <= 1'b0;
      rdata         <= '0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
    end else begin
      state <= state_nx;
      err   <= err_nx;
      if (latch_req) begin
        mem.mem_we    <= MemWrite;
        mem.mem_addr  <= addr;
        mem.mem_wdata <= wdata;
      end
      if (cap_rdata) begin
        rdata <= mem.mem_rdata;
      end else if (clr_rdata) begin
        rdata <= '0;
      end
    end
  end

  always_comb begin
    state_nx    = state;
    stall       = 1'b0;
    done        = 1'b0;
    mem.mem_req = 1'b0;
    err_nx      = 1'b0;
    latch_req   = 1'b0;
    cap_rdata   = 1'b0;
    clr_rdata   = 1'b0;
    case (state)
      IDLE: begin
        if (legal) begin
          stall     = 1'b1;
          latch_req = 1'b1;
          state_nx  = REQ;
        end else if (MemRead || MemWrite) begin
          err_nx = 1'b1;
        end
      end
      REQ: begin
        stall       = 1'b1;
        mem.mem_req = 1'b1;
        if (mem.mem_gnt && mem.mem_we) begin
          state_nx = DONE;
        end else if (expired) begin
          err_nx    = 1'b1;
          clr_rdata = !mem.mem_we;
          state_nx  = DONE;
        end else if (mem.mem_gnt) begin
          state_nx = WAIT_R;
        end
      end
      WAIT_R: begin
        stall = 1'b1;
        if (mem.mem_rvalid) begin
          cap_rdata = 1'b1;
          state_nx  = DONE;
        end else if (expired) begin
          err_nx    = 1'b1;
          clr_rdata = 1'b1;
          state_nx  = DONE;
        end
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed and randomized checks of data_mem_ctrl against a cycle-count model
// derived from the access rules (stall length, grant count, retire data).
module tb_data_mem_ctrl;
  import data_mem_ctrl_pkg::*;

  localparam int TO = 255;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead, MemWrite;
  logic [63:0] addr, wdata, rdata;
  logic        stall, done, err;

  int          vectors = 0;
  int          miscompares = 0;
  logic [63:0] model_rdata = '0;

  data_mem_ctrl_if mem ();

  data_mem_ctrl #(.ADDR_W(64), .DATA_W(64), .TIMEOUT(TO)) dut (
    .clk      (clk),
    .reset    (reset),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .stall    (stall),
    .done     (done),
    .err      (err),
    .mem      (mem.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_cycle(input string tag);
    @(posedge clk); #1;
    MemRead = 1'b0; MemWrite = 1'b0;
    mem.mem_gnt = 1'b0; mem.mem_rvalid = 1'b0;
    @(negedge clk);
    chk({tag, "_stall"}, 64'(stall), 64'(0));
    chk({tag, "_req"},   64'(mem.mem_req), 64'(0));
    chk({tag, "_done"},  64'(done), 64'(0));
    chk({tag, "_rdata"}, rdata, model_rdata);
  endtask

  // g: REQ cycles before the grant (g < 0: never grant); r: cycles from grant to rvalid.
  task automatic do_access(input string tag, input logic rd, input logic wr,
                           input logic [63:0] a, input logic [63:0] wd,
                           input int g, input int r, input logic [63:0] rd_val);
    int   stall_n = 0, req_n = 0, done_n = 0, err_n = 0, since = 0;
    int   first_req = -1, stall_exp, req_exp;
    logic granted = 1'b0, bad_hold = 1'b0, err_at_done = 1'b0, stall_at_done = 1'b1;
    logic [63:0] rdata_at_done = '0;
    bit   never;
    never = (g < 0);
    for (int cyc = 0; cyc < 600 && done_n == 0; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 0) begin
        MemRead = rd; MemWrite = wr; addr = a; wdata = wd;
      end
      if (granted) since++;
      mem.mem_rvalid = rd && granted && (since == r);
      mem.mem_rdata  = mem.mem_rvalid ? rd_val : {$urandom(), $urandom()};
      mem.mem_gnt    = mem.mem_req && !never && (req_n == g);
      if (mem.mem_gnt) granted = 1'b1;
      @(negedge clk);
      if (stall) stall_n++;
      if (err) err_n++;
      if (mem.mem_req) begin
        if (first_req < 0) first_req = cyc;
        req_n++;
        if (mem.mem_we !== wr || mem.mem_addr !== a || mem.mem_wdata !== wd) bad_hold = 1'b1;
      end
      if (done) begin
        done_n++;
        err_at_done   = err;
        stall_at_done = stall;
        rdata_at_done = rdata;
      end
    end
    stall_exp = never ? 1 + TO : 1 + (g + 1) + (rd ? r : 0);
    req_exp   = never ? TO : g + 1;
    if (rd) model_rdata = never ? 64'd0 : rd_val;
    chk({tag, "_done"},      64'(done_n), 64'(1));
    chk({tag, "_stall_len"}, 64'(stall_n), 64'(stall_exp));
    chk({tag, "_req_len"},   64'(req_n), 64'(req_exp));
    chk({tag, "_first_req"}, 64'(first_req), 64'(1));
    chk({tag, "_bus_hold"},  64'(bad_hold), 64'(0));
    chk({tag, "_err"},       64'(err_at_done), 64'(never));
    chk({tag, "_err_cnt"},   64'(err_n), 64'(never ? 1 : 0));
    chk({tag, "_stall_dn"},  64'(stall_at_done), 64'(0));
    chk({tag, "_rdata"},     rdata_at_done, model_rdata);
  endtask

  task automatic do_illegal(input string tag, input logic rd, input logic wr,
                            input logic [63:0] a);
    @(posedge clk); #1;
    MemRead = rd; MemWrite = wr; addr = a; wdata = {$urandom(), $urandom()};
    mem.mem_gnt = 1'b0; mem.mem_rvalid = 1'b0;
    @(negedge clk);
    chk({tag, "_stall0"}, 64'(stall), 64'(0));
    chk({tag, "_req0"},   64'(mem.mem_req), 64'(0));
    chk({tag, "_err0"},   64'(err), 64'(0));
    @(posedge clk); #1;
    MemRead = 1'b0; MemWrite = 1'b0;
    @(negedge clk);
    chk({tag, "_err1"},   64'(err), 64'(1));
    chk({tag, "_req1"},   64'(mem.mem_req), 64'(0));
    chk({tag, "_stall1"}, 64'(stall), 64'(0));
    chk({tag, "_done1"},  64'(done), 64'(0));
    chk({tag, "_rdata"},  rdata, model_rdata);
    @(posedge clk); #1;
    @(negedge clk);
    chk({tag, "_err2"},   64'(err), 64'(0));
  endtask

  initial begin
    reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; addr = '0; wdata = '0;
    mem.mem_gnt = 1'b0; mem.mem_rvalid = 1'b0; mem.mem_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rdata", rdata, 64'd0);
    chk("rst_stall", 64'(stall), 64'(0));
    chk("rst_req",   64'(mem.mem_req), 64'(0));
    chk("rst_we",    64'(mem.mem_we), 64'(0));
    chk("rst_addr",  mem.mem_addr, 64'd0);
    chk("rst_wdata", mem.mem_wdata, 64'd0);
    chk("rst_done",  64'(done), 64'(0));
    chk("rst_err",   64'(err), 64'(0));
    @(posedge clk); #1;
    reset = 1'b0;

    do_access("st10", 1'b0, 1'b1, 64'h10, 64'hDEADBEEF, 0, 0, 64'd0);
    idle_cycle("idle_a");
    do_access("ld18", 1'b1, 1'b0, 64'h18, 64'h5555, 3, 2, 64'h1234);
    idle_cycle("idle_b");
    do_illegal("both", 1'b1, 1'b1, 64'h20);
    do_illegal("mis13", 1'b1, 1'b0, 64'h13);
    do_access("ld_to", 1'b1, 1'b0, 64'h40, 64'h0, -1, 1, 64'hFFFF);
    idle_cycle("idle_c");

    do_access("ld_pre", 1'b1, 1'b0, 64'h28, 64'h0, 0, 1, 64'hCAFE_F00D_1234_5678);
    @(posedge clk); #1;
    MemRead = 1'b1; MemWrite = 1'b0; addr = 64'h30;
    @(posedge clk); #1;
    mem.mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem.mem_gnt = 1'b0;
    @(negedge clk);
    chk("wr_stall_wait", 64'(stall), 64'(1));
    @(posedge clk); #1;
    reset = 1'b1; MemRead = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    mem.mem_rvalid = 1'b1; mem.mem_rdata = 64'hBAD0_BAD0;
    model_rdata = 64'd0;
    @(negedge clk);
    chk("wr_rst_stall", 64'(stall), 64'(0));
    chk("wr_rst_req",   64'(mem.mem_req), 64'(0));
    chk("wr_rst_rdata", rdata, 64'd0);
    @(posedge clk); #1;
    mem.mem_rvalid = 1'b0;
    @(negedge clk);
    chk("wr_late_rdata", rdata, 64'd0);
    chk("wr_late_done",  64'(done), 64'(0));
    chk("wr_late_err",   64'(err), 64'(0));

    do_access("b2b_st", 1'b0, 1'b1, 64'h48, 64'h7777_8888, 0, 0, 64'd0);
    do_access("b2b_ld", 1'b1, 1'b0, 64'h50, 64'h0, 0, 1, 64'h0BAD_CAFE);

    for (int i = 0; i < 40; i++) begin
      int          kind;
      logic [63:0] ra;
      kind = int'($urandom_range(0, 7));
      ra   = {$urandom(), $urandom()};
      if (kind <= 5) begin
        ra[2:0] = 3'b000;
        do_access("rnd", kind[0], !kind[0], ra, {$urandom(), $urandom()},
                  int'($urandom_range(0, 5)), int'($urandom_range(1, 4)),
                  {$urandom(), $urandom()});
      end else if (kind == 6) begin
        do_illegal("rnd_both", 1'b1, 1'b1, ra);
      end else begin
        if (ra[2:0] == 3'b000) ra[0] = 1'b1;
        do_illegal("rnd_mis", $urandom_range(0, 1) == 1, 1'b0, ra);
      end
      repeat ($urandom_range(0, 2)) idle_cycle("rnd_idle");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
